top: RTL and testbench
======================

TOP -- requirements
Module: top

Interface
REQ-001 The module SHALL have no parameters; the data width is fixed at 16 bits.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 enable  input  1  count enable; sampled on rising clk.
REQ-005 counter  output  16  error-corrected current count value.

Function
REQ-006 The module SHALL contain one submodule instance named counter_and_parity.
- It SHALL hold a 16-bit register count_reg (raw count).
- It SHALL hold a 5-bit register parity_stored (Hamming check bits).
REQ-007 Check bits SHALL use Hamming(21,16) SEC over codeword positions 1..21.
- Check bits sit at positions 1, 2, 4, 8, 16.
- Data bits d0..d15 fill the remaining positions in ascending order: d0 at 3, d1 at 5, d2 at 6, d3 at 7, d4..d10 at 9..15, d11..d15 at 17..21.
REQ-008 Check bit k (k = 0..4) SHALL be the XOR of all data bits whose position has bit k set.
REQ-009 The syndrome SHALL be computed combinationally from count_reg and parity_stored, as recomputed check bits XOR parity_stored (5 bits).
REQ-010 The corrected value SHALL be derived from the syndrome as follows:
- Syndrome naming a data position: count_reg with that bit inverted.
- Syndrome 0, naming a check-bit position, or greater than 21: count_reg unchanged.
REQ-011 counter SHALL equal the corrected value combinationally, with no extra register stage.
REQ-012 On a rising clk with enable=1:
- count_reg SHALL load corrected+1, modulo 2^16.
- parity_stored SHALL load the check bits of that new value.
REQ-013 On a rising clk with enable=0:
- count_reg SHALL load the corrected value (scrub).
- parity_stored SHALL load the check bits of the corrected value.
REQ-014 Wrap-around: corrected value 0xFFFF with enable=1 SHALL produce 0x0000 on the next edge, with no flag.
REQ-015 A single-bit upset in count_reg or parity_stored SHALL never be visible on counter.
- The upset SHALL be removed from the registers at the next rising edge.
REQ-016 Multi-bit upsets are not guaranteed to be corrected.
- The module SHALL still continue counting from its corrected value.
- Registers SHALL be re-encoded consistently at the next edge; no lock-up.
REQ-017 Counting latency SHALL be one edge: counter shows the incremented value immediately after the edge at which enable=1 is sampled.

Reset
REQ-018 reset=1 SHALL immediately, without waiting for clk, force count_reg=0x0000 and parity_stored=5'b00000, so that counter=0x0000.
REQ-019 While reset=1, clk edges and enable SHALL be ignored.
REQ-020 Reset asserted mid-count SHALL discard the count.
- Counting resumes from 0x0000 at the first edge with reset=0 and enable=1.

Verification
REQ-021 Basic count:
- Stimulus: reset, release with enable=1 for 10 edges.
- Required: counter steps 1..10 and ends at 0x000A.
REQ-022 Hold:
- Stimulus: then enable=0 for 6 edges.
- Required: counter stays 0x000A; then enable=1 for 5 edges gives 0x000F.
REQ-023 Data upset:
- Stimulus: at count 0x000F, invert count_reg[3].
- Required: counter still reads 0x000F in the same cycle, next edge with enable=1 gives 0x0010, and the syndrome is 0 afterwards.
REQ-024 Parity upset:
- Stimulus: invert parity_stored[0] with enable=0.
- Required: counter unchanged; after one edge parity_stored matches the check bits of count_reg.
REQ-025 Multi-bit upset:
- Stimulus: force count_reg=0x013A while parity_stored encodes 0x000F, then release.
- Required: no X or lock-up; within 1 edge the syndrome is 0 and counting continues by +1 per enabled edge.
REQ-026 Wrap and reset:
- Stimulus: preload to 0xFFFF with consistent parity, then enable=1 for one edge.
- Required: counter reads 0x0000.
- Stimulus: assert reset asynchronously mid-count.
- Required: counter reads 0x0000 before the next clk edge.

Source files
------------

// File: rtl/top.sv
// ---------------------------------------------------------------------------
// top -- 16-bit up-counter whose state is protected by Hamming(21,16) SEC.
//
// The raw count and its five check bits live in the counter_and_parity
// instance. Every edge re-encodes the register from the corrected value, so a
// single-bit upset is never visible on the output and is scrubbed at the next
// edge whether or not counting is enabled.
//
// Ports
//   clk      in   1  sole clock, rising edge
//   reset    in   1  asynchronous, active-high reset
//   enable   in   1  count enable, sampled on rising clk
//   counter  out 16  error-corrected current count
// ---------------------------------------------------------------------------
module top (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [15:0] counter
);

  ecc_count_core counter_and_parity (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .counter (counter)
  );

endmodule

// ---------------------------------------------------------------------------
// ecc_count_core -- count register plus stored Hamming check bits.
//
// Codeword layout (positions 1..21): check bits at 1,2,4,8,16; data d0..d15
// at 3,5,6,7,9..15,17..21. The syndrome is the position of a single flipped
// bit; only data positions need repair since the check bits are regenerated
// from the corrected value on every edge anyway.
//
// Ports
//   clk      in   1  sole clock, rising edge
//   reset    in   1  asynchronous, active-high reset
//   enable   in   1  count enable
//   counter  out 16  corrected count (combinational from the registers)
// ---------------------------------------------------------------------------
module ecc_count_core (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [15:0] counter
);

  logic [15:0] count_reg;
  logic [4:0]  parity_stored;
  logic [4:0]  syndrome;
  logic [15:0] flip_mask;
  logic [15:0] corrected;
  logic [15:0] next_count;

  // Check bit k covers every data bit whose codeword position has bit k set.
  function automatic logic [4:0] check_bits(input logic [15:0] d);
    logic [4:0] c;
    c[0] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10] ^ d[11] ^ d[13] ^ d[15];
    c[1] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[10] ^ d[12] ^ d[13];
    c[2] = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[10] ^ d[14] ^ d[15];
    c[3] = d[4] ^ d[5] ^ d[6] ^ d[7] ^ d[8] ^ d[9] ^ d[10];
    c[4] = d[11] ^ d[12] ^ d[13] ^ d[14] ^ d[15];
    return c;
  endfunction

  assign syndrome = check_bits(count_reg) ^ parity_stored;

  // Syndrome -> data bit to invert. Zero, check-bit positions (1,2,4,8,16)
  // and out-of-range values (22..31) leave the data untouched.
  always_comb begin
    flip_mask = 16'h0000;
    case (syndrome)
      5'd3:    flip_mask = 16'h0001;
      5'd5:    flip_mask = 16'h0002;
      5'd6:    flip_mask = 16'h0004;
      5'd7:    flip_mask = 16'h0008;
      5'd9:    flip_mask = 16'h0010;
      5'd10:   flip_mask = 16'h0020;
      5'd11:   flip_mask = 16'h0040;
      5'd12:   flip_mask = 16'h0080;
      5'd13:   flip_mask = 16'h0100;
      5'd14:   flip_mask = 16'h0200;
      5'd15:   flip_mask = 16'h0400;
      5'd17:   flip_mask = 16'h0800;
      5'd18:   flip_mask = 16'h1000;
      5'd19:   flip_mask = 16'h2000;
      5'd20:   flip_mask = 16'h4000;
      5'd21:   flip_mask = 16'h8000;
      default: flip_mask = 16'h0000;
    endcase
  end

  assign corrected  = count_reg ^ flip_mask;
  assign counter    = corrected;
  // Wraps silently from 0xFFFF to 0x0000.
  assign next_count = enable ? corrected + 16'd1 : corrected;

  // Both registers reload every edge: with enable low this is a pure scrub.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg     <= 16'h0000;
      parity_stored <= 5'b00000;
    end else begin
      count_reg     <= next_count;
      parity_stored <= check_bits(next_count);
    end
  end

endmodule

// File: tb/tb_top.sv
module tb_top;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [15:0] counter;

  int tests_run;
  int tests_failed;

  logic [15:0] sb[$];
  logic [15:0] exp_v;
  logic [15:0] last_v;

  top dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .counter (counter)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference encoder built by walking codeword positions, independent of
  // any hand-expanded XOR tree.
  function automatic logic [4:0] ref_enc(input logic [15:0] d);
    logic [4:0] c;
    int j;
    c = 5'b0;
    j = 0;
    for (int p = 1; p <= 21; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (d[j]) c = c ^ 5'(p);
        j++;
      end
    end
    return c;
  endfunction

  function automatic logic [15:0] ref_correct(input logic [15:0] d, input logic [4:0] par);
    logic [4:0]  syn;
    logic [15:0] r;
    int j;
    syn = ref_enc(d) ^ par;
    r = d;
    j = 0;
    for (int p = 1; p <= 21; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (p == int'(syn)) r[j] = ~r[j];
        j++;
      end
    end
    return r;
  endfunction

  // Drive one edge and record the value the counter must show after it.
  task automatic step(input logic en, input logic [15:0] expect_after);
    @(negedge clk);
    enable = en;
    sb.push_back(expect_after);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (counter !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_counter got %h want 0000", counter);
    end
    tests_run++;
    if (dut.counter_and_parity.parity_stored !== 5'b00000) begin
      tests_failed++;
      $display("FAIL reset_parity got %b want 00000", dut.counter_and_parity.parity_stored);
    end
    @(negedge clk);
    reset = 1'b0;
    enable = 1'b0;
    sb.delete();
    last_v = 16'h0000;
  endtask

  task automatic test_count();
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 16'(i));
      exp_v = sb.pop_front();
      tests_run++;
      if (counter !== exp_v) begin
        tests_failed++;
        $display("FAIL count_step%0d got %h want %h", i, counter, exp_v);
      end
    end
    last_v = 16'h000A;
  endtask

  task automatic test_hold();
    for (int i = 0; i < 6; i++) begin
      step(1'b0, last_v);
      exp_v = sb.pop_front();
      tests_run++;
      if (counter !== exp_v) begin
        tests_failed++;
        $display("FAIL hold_step%0d got %h want %h", i, counter, exp_v);
      end
    end
    for (int i = 1; i <= 5; i++) begin
      last_v = last_v + 16'd1;
      step(1'b1, last_v);
    end
    while (sb.size() > 1) void'(sb.pop_front());
    exp_v = sb.pop_front();
    tests_run++;
    if (counter !== exp_v || exp_v !== 16'h000F) begin
      tests_failed++;
      $display("FAIL hold_resume got %h want %h", counter, 16'h000F);
    end
  endtask

  task automatic test_data_upset();
    logic [15:0] bad;
    @(negedge clk);
    enable = 1'b0;
    bad = dut.counter_and_parity.count_reg ^ 16'h0008;
    force dut.counter_and_parity.count_reg = bad;
    #1;
    tests_run++;
    if (counter !== 16'h000F) begin
      tests_failed++;
      $display("FAIL data_upset_masked got %h want 000F", counter);
    end
    release dut.counter_and_parity.count_reg;
    #1;
    tests_run++;
    if (counter !== ref_correct(dut.counter_and_parity.count_reg, dut.counter_and_parity.parity_stored)
        || counter !== 16'h000F) begin
      tests_failed++;
      $display("FAIL data_upset_release got %h want 000F", counter);
    end
    step(1'b1, 16'h0010);
    exp_v = sb.pop_front();
    tests_run++;
    if (counter !== exp_v) begin
      tests_failed++;
      $display("FAIL data_upset_next got %h want %h", counter, exp_v);
    end
    tests_run++;
    if (dut.counter_and_parity.syndrome !== 5'd0) begin
      tests_failed++;
      $display("FAIL data_upset_syndrome got %0d want 0", dut.counter_and_parity.syndrome);
    end
    last_v = 16'h0010;
  endtask

  task automatic test_parity_upset();
    logic [4:0] badp;
    @(negedge clk);
    enable = 1'b0;
    badp = dut.counter_and_parity.parity_stored ^ 5'b00001;
    force dut.counter_and_parity.parity_stored = badp;
    #1;
    tests_run++;
    if (counter !== last_v) begin
      tests_failed++;
      $display("FAIL parity_upset_masked got %h want %h", counter, last_v);
    end
    release dut.counter_and_parity.parity_stored;
    step(1'b0, last_v);
    exp_v = sb.pop_front();
    tests_run++;
    if (counter !== exp_v) begin
      tests_failed++;
      $display("FAIL parity_upset_hold got %h want %h", counter, exp_v);
    end
    tests_run++;
    if (dut.counter_and_parity.parity_stored !== ref_enc(exp_v)) begin
      tests_failed++;
      $display("FAIL parity_upset_scrub got %b want %b",
               dut.counter_and_parity.parity_stored, ref_enc(exp_v));
    end
  endtask

  task automatic test_multi_upset();
    logic [15:0] corr;
    @(negedge clk);
    enable = 1'b0;
    corr = ref_correct(16'h013A, ref_enc(16'h000F));
    force dut.counter_and_parity.count_reg = 16'h013A;
    force dut.counter_and_parity.parity_stored = ref_enc(16'h000F);
    #1;
    release dut.counter_and_parity.count_reg;
    release dut.counter_and_parity.parity_stored;
    #1;
    tests_run++;
    if ($isunknown(counter) || counter !== corr) begin
      tests_failed++;
      $display("FAIL multi_upset_comb got %h want %h", counter, corr);
    end
    step(1'b1, corr + 16'd1);
    exp_v = sb.pop_front();
    tests_run++;
    if (counter !== exp_v) begin
      tests_failed++;
      $display("FAIL multi_upset_step got %h want %h", counter, exp_v);
    end
    tests_run++;
    if (dut.counter_and_parity.syndrome !== 5'd0) begin
      tests_failed++;
      $display("FAIL multi_upset_syndrome got %0d want 0", dut.counter_and_parity.syndrome);
    end
    last_v = exp_v;
    for (int i = 0; i < 3; i++) begin
      last_v = last_v + 16'd1;
      step(1'b1, last_v);
      exp_v = sb.pop_front();
      tests_run++;
      if (counter !== exp_v) begin
        tests_failed++;
        $display("FAIL multi_upset_cont%0d got %h want %h", i, counter, exp_v);
      end
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    enable = 1'b0;
    force dut.counter_and_parity.count_reg = 16'hFFFF;
    force dut.counter_and_parity.parity_stored = ref_enc(16'hFFFF);
    #1;
    release dut.counter_and_parity.count_reg;
    release dut.counter_and_parity.parity_stored;
    #1;
    tests_run++;
    if (counter !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL wrap_preload got %h want FFFF", counter);
    end
    step(1'b1, 16'h0000);
    exp_v = sb.pop_front();
    tests_run++;
    if (counter !== exp_v) begin
      tests_failed++;
      $display("FAIL wrap_edge got %h want %h", counter, exp_v);
    end
    tests_run++;
    if (dut.counter_and_parity.parity_stored !== ref_enc(16'h0000)) begin
      tests_failed++;
      $display("FAIL wrap_parity got %b want %b",
               dut.counter_and_parity.parity_stored, ref_enc(16'h0000));
    end
    last_v = 16'h0000;
  endtask

  task automatic test_async_reset();
    for (int i = 1; i <= 4; i++) begin
      last_v = last_v + 16'd1;
      step(1'b1, last_v);
      exp_v = sb.pop_front();
      tests_run++;
      if (counter !== exp_v) begin
        tests_failed++;
        $display("FAIL pre_reset_step%0d got %h want %h", i, counter, exp_v);
      end
    end
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if (counter !== 16'h0000) begin
      tests_failed++;
      $display("FAIL async_reset got %h want 0000", counter);
    end
    enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (counter !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_holds got %h want 0000", counter);
    end
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    enable = 1'b0;
    step(1'b1, 16'h0001);
    exp_v = sb.pop_front();
    tests_run++;
    if (counter !== exp_v) begin
      tests_failed++;
      $display("FAIL post_reset_step got %h want %h", counter, exp_v);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    reset = 1'b1;
    enable = 1'b0;
    test_reset();
    test_count();
    test_hold();
    test_data_upset();
    test_parity_upset();
    test_multi_upset();
    test_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
